// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port CPU/host arbiter owning the data RAM pins; fixed 3+RAM_LAT cycle access.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed CPU priority.
module mem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int RAM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_wen,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_valid,
    input  logic          host_req,
    input  logic          host_wen,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_valid,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [1:0]    grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_d;
    logic       load;
    logic       win_host;
    logic       capture;
    logic       lat_wen;
    logic [2:0] cnt;

`ifdef MEM_ARB_RR_EN
    logic       last_host;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        load     = 1'b0;
        win_host = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || host_req) begin
                    load    = 1'b1;
                    state_d = ACCESS;
`ifdef MEM_ARB_RR_EN
                    win_host = host_req && (!cpu_req || !last_host);
`else
                    win_host = host_req && !cpu_req;
`endif
                end
            end
            ACCESS: state_d = WAIT;
            WAIT: begin
                if (cnt == 3'd1) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The RAM address/data registers double as the latched request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            lat_wen    <= 1'b0;
            cnt        <= 3'd0;
            grant      <= 2'b00;
            cpu_valid  <= 1'b0;
            host_valid <= 1'b0;
            cpu_rdata  <= '0;
            host_rdata <= '0;
`ifdef MEM_ARB_RR_EN
            last_host  <= 1'b1;
`endif
        end else begin
            ram_ce     <= load;
            ram_we     <= load && (win_host ? host_wen : cpu_wen);
            cpu_valid  <= capture && grant[0];
            host_valid <= capture && grant[1];

            if (load) begin
                lat_wen   <= win_host ? host_wen : cpu_wen;
                ram_addr  <= win_host ? host_addr : cpu_addr;
                ram_wdata <= win_host ? host_wdata : cpu_wdata;
                grant     <= win_host ? 2'b10 : 2'b01;
`ifdef MEM_ARB_RR_EN
                last_host <= win_host;
`endif
            end else if (state == DONE) begin
                grant <= 2'b00;
            end

            if (state == ACCESS) begin
                cnt <= 3'(RAM_LAT);
            end else if (state == WAIT) begin
                cnt <= cnt - 3'd1;
            end

            if (capture && !lat_wen) begin
                if (grant[0]) cpu_rdata  <= ram_rdata;
                if (grant[1]) host_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single data RAM between the CPU control FSM's memory stage (LOAD/STORE) and a host loader/debug port. Each requester uses a level request and a one-cycle completion pulse. The CPU's existing `ram_en`/`wen`/`ram_valid` handshake connects directly, with no change to the CPU side. The block sits between the CPU core, the host interface and the RAM. It owns the RAM control pins and sequences each access through a fixed-latency pipeline.

## Interface
Parameters:
- `AW`, 8, RAM address width.
- `DW`, 8, RAM data width.
- `RAM_LAT`, 1, RAM read latency in cycles from the `ram_ce` cycle to valid `ram_rdata`. Legal range 1..4.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU access request (level); driven by CPU `ram_en`.
- `cpu_wen`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_rdata`  out  DW  CPU read data; held until the next CPU read completes.
- `cpu_valid`  out  1  one-cycle completion pulse; driven to CPU `ram_valid`.
- `host_req`, `host_wen`, `host_addr`, `host_wdata`, `host_rdata`, `host_valid`  same as the CPU set, for the host port.
- `ram_ce`  out  1  RAM chip enable, one cycle per access.
- `ram_we`  out  1  RAM write enable; qualified by `ram_ce`.
- `ram_addr`  out  AW  RAM address.
- `ram_wdata`  out  DW  RAM write data.
- `ram_rdata`  in  DW  RAM read data, valid `RAM_LAT` cycles after the `ram_ce` cycle.
- `grant`  out  2  one-hot current owner: bit0 = CPU, bit1 = host. 00 when idle.

## Operation
- State machine: IDLE -> ACCESS -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any request is pending, select a winner.
  - Latch the winner's `wen`/`addr`/`wdata` into internal registers and set `grant`.
  - Go to ACCESS.
  - Request fields only need to be stable in the grant cycle; `req` must stay high until `valid`.
- ACCESS: `ram_ce`=1, `ram_we`=latched `wen`, address/data from latched registers. Go to WAIT.
- WAIT:
  - A down-counter is loaded with `RAM_LAT` on entry and decremented each cycle.
  - At count 1, capture `ram_rdata` (reads only) and go to DONE.
- DONE:
  - Pulse the owner's `valid` for exactly one cycle.
  - For reads, update the owner's `rdata`; the other port's `rdata` is untouched.
  - Clear `grant` and return to IDLE.
  - Requests are not sampled in DONE, so a requester that drops `req` on its `valid` cycle is never served twice.
- Arbitration applies only when both requests are high in IDLE. A lone requester is always granted.
- A request deasserted before its `valid` (protocol violation) does not abort the access; it still completes and pulses `valid`.
- Writes follow the identical sequence and latency as reads. `rdata` is unchanged on writes.
- Reset (any state, including mid-access):
  - State returns to IDLE; the in-flight access is dropped with no `valid`.
  - `ram_ce`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
  - `cpu_valid`=0, `host_valid`=0, `cpu_rdata`=0, `host_rdata`=0, `grant`=00.
  - Round-robin pointer set to "host served last".

## Timing
- All outputs are registered.
- With `req` first high in IDLE cycle t0:
  - `ram_ce` is high in cycle t0+1.
  - `valid` is high in cycle t0+2+`RAM_LAT`. That is t0+3 for the default `RAM_LAT`.
- Back-to-back: the earliest next grant is sampled in the IDLE cycle after DONE. Throughput is one access per 3+`RAM_LAT` cycles.
- A losing requester waits exactly one full access (3+`RAM_LAT` cycles) when the other port does not re-request.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On a tie, grant the port not served last. The pointer updates on every grant, and after reset the CPU wins the first tie.
- Undefined: fixed priority, CPU always wins ties. The host can starve while the CPU re-requests continuously.

## Test plan
- CPU read alone: preload RAM[0x12]=0xA5 and assert `cpu_req` with `cpu_wen`=0. Required: `ram_ce` at t0+1 with `ram_addr`=0x12, `cpu_valid` one cycle at t0+3, `cpu_rdata`=0xA5, `host_rdata` unchanged.
- Host write then CPU read: host writes 0x3C to 0x40, then CPU reads 0x40. Required: `ram_we`=1 only in the host ACCESS cycle, and CPU reads 0x3C.
- Tie, both requesting continuously for 4 accesses:
  - With `MEM_ARB_RR_EN`: grants go CPU, host, CPU, host.
  - Without it: CPU, CPU, CPU, CPU.
- CPU holds `req` through its `valid` cycle and drops it after. Required: exactly one `cpu_valid` and no second `ram_ce`.
- `rst` asserted during WAIT of a host read. Required: next cycle IDLE with all outputs at reset values. No `host_valid` ever appears for that read.
- `RAM_LAT`=3: a CPU read has `valid` at t0+5. The captured data matches the value presented on `ram_rdata` 3 cycles after `ram_ce`.
